park_gate_fsm: RTL and testbench

PARK_GATE_FSM -- requirements
Module: park_gate_fsm

---
 rtl/park_gate_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_park_gate_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/park_gate_fsm.sv
// Parking gate controller: synchronizes and debounces two beam sensors, then tracks entry/exit order.
// Optional build macro PARK_GATE_TIMEOUT_EN adds a per-state watchdog of TIMEOUT_CYCLES.
module park_gate_fsm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 15,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic [3:0] occupancy,
  output logic       car_in,
  output logic       car_out,
  output logic       gate_open,
  output logic       denied,
  output logic       error
);

  typedef enum logic [3:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, DENY, CLEAR
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 1 carries sensor A, bit 0 carries sensor B throughout.
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_deb;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t r_state;
  state_t w_next;
  logic   w_car_in, w_car_out, w_denied, w_error, w_gate;
  logic   w_room;
  logic   w_tmo;
  logic   r_car_in, r_car_out, r_denied, r_error, r_gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
      r_deb  <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_meta <= {sensor_a, sensor_b};
      r_sync <= r_meta;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_room = 32'(occupancy) < CAPACITY;

`ifdef PARK_GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  assign w_tmo = (r_state != IDLE) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Restarts on any state change and after each timeout, so CLEAR can time out repeatedly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == IDLE || w_tmo || w_next != r_state) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_car_in  = 1'b0;
    w_car_out = 1'b0;
    w_denied  = 1'b0;
    w_error   = 1'b0;
    unique case (r_state)
      IDLE: begin
        unique case (r_deb)
          2'b00: w_next = IDLE;
          2'b10: begin
            if (w_room) begin
              w_next = IN_A;
            end else begin
              w_next   = DENY;
              w_denied = 1'b1;
            end
          end
          2'b01: w_next = OUT_B;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      IN_A: begin
        unique case (r_deb)
          2'b10: w_next = IN_A;
          2'b11: w_next = IN_AB;
          2'b00: w_next = IDLE;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      IN_AB: begin
        unique case (r_deb)
          2'b11: w_next = IN_AB;
          2'b01: w_next = IN_B;
          2'b10: w_next = IN_A;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      IN_B: begin
        unique case (r_deb)
          2'b01: w_next = IN_B;
          2'b00: begin w_next = IDLE; w_car_in = 1'b1; end
          2'b11: w_next = IN_AB;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      OUT_B: begin
        unique case (r_deb)
          2'b01: w_next = OUT_B;
          2'b11: w_next = OUT_AB;
          2'b00: w_next = IDLE;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      OUT_AB: begin
        unique case (r_deb)
          2'b11: w_next = OUT_AB;
          2'b10: w_next = OUT_A;
          2'b01: w_next = OUT_B;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      OUT_A: begin
        unique case (r_deb)
          2'b10: w_next = OUT_A;
          2'b00: begin w_next = IDLE; w_car_out = 1'b1; end
          2'b11: w_next = OUT_AB;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      DENY: begin
        unique case (r_deb)
          2'b00: w_next = IDLE;
          2'b10: w_next = DENY;
          default: begin w_next = CLEAR; w_error = 1'b1; end
        endcase
      end
      CLEAR: begin
        if (r_deb == 2'b00) w_next = IDLE;
      end
      default: begin w_next = CLEAR; w_error = 1'b1; end
    endcase
    // Watchdog overrides whatever the sensors asked for.
    if (w_tmo) begin
      w_next    = CLEAR;
      w_car_in  = 1'b0;
      w_car_out = 1'b0;
      w_denied  = 1'b0;
      w_error   = 1'b1;
    end
    w_gate = (w_next == IN_A)  || (w_next == IN_AB)  || (w_next == IN_B) ||
             (w_next == OUT_B) || (w_next == OUT_AB) || (w_next == OUT_A);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_car_in  <= 1'b0;
      r_car_out <= 1'b0;
      r_denied  <= 1'b0;
      r_error   <= 1'b0;
      r_gate    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_car_in  <= w_car_in;
      r_car_out <= w_car_out;
      r_denied  <= w_denied;
      r_error   <= w_error;
      r_gate    <= w_gate;
    end
  end

  assign car_in    = r_car_in;
  assign car_out   = r_car_out;
  assign denied    = r_denied;
  assign error     = r_error;
  assign gate_open = r_gate;

endmodule

// File: tb/tb_park_gate_fsm.sv
// Directed bench for park_gate_fsm: entry, exit, deny, backing out, bounce, illegal order, reset, watchdog.
module tb_park_gate_fsm;

`ifdef PARK_GATE_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_a = 1'b0;
  logic       sensor_b = 1'b0;
  logic [3:0] occupancy = 4'd3;
  logic       car_in, car_out, gate_open, denied, error;

  int n_cmp = 0;
  int n_bad = 0;
  int c_in = 0, c_out = 0, c_den = 0, c_err = 0, c_gate = 0, c_multi = 0;
  int s_in, s_out, s_den, s_err, s_gate;

  always #5 clk = ~clk;

  park_gate_fsm #(
    .DEBOUNCE_CYCLES(4),
    .CAPACITY(15),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .occupancy(occupancy),
    .car_in(car_in),
    .car_out(car_out),
    .gate_open(gate_open),
    .denied(denied),
    .error(error)
  );

  // Running tallies of output activity, one sample per cycle.
  always @(negedge clk) begin
    if (!rst) begin
      c_in    <= c_in + int'(car_in);
      c_out   <= c_out + int'(car_out);
      c_den   <= c_den + int'(denied);
      c_err   <= c_err + int'(error);
      c_gate  <= c_gate + int'(gate_open);
      c_multi <= c_multi + int'((int'(car_in) + int'(car_out) + int'(denied) + int'(error)) > 1);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_in = c_in; s_out = c_out; s_den = c_den; s_err = c_err; s_gate = c_gate;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst car_in", int'(car_in), 0);
    chk("rst car_out", int'(car_out), 0);
    chk("rst gate_open", int'(gate_open), 0);
    chk("rst denied", int'(denied), 0);
    chk("rst error", int'(error), 0);
    rst = 1'b0;
    hold(0, 0, 10);

    // Normal entry with room available
    snap();
    hold(1, 0, 10);
    chk("entry gate in IN_A", int'(gate_open), 1);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("entry car_in", c_in - s_in, 1);
    chk("entry car_out", c_out - s_out, 0);
    chk("entry error", c_err - s_err, 0);
    chk("entry gate cycles", c_gate - s_gate, 30);
    chk("entry gate after", int'(gate_open), 0);

    // Normal exit
    snap();
    hold(0, 1, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 10);
    chk("exit car_out", c_out - s_out, 1);
    chk("exit car_in", c_in - s_in, 0);
    chk("exit gate cycles", c_gate - s_gate, 30);

    // Lot full
    occupancy = 4'd15;
    snap();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("full denied", c_den - s_den, 1);
    chk("full car_in", c_in - s_in, 0);
    chk("full gate cycles", c_gate - s_gate, 0);

    // One below capacity is still admitted
    occupancy = 4'd14;
    snap();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("occ14 car_in", c_in - s_in, 1);
    chk("occ14 denied", c_den - s_den, 0);
    occupancy = 4'd3;

    // Backing out of entry and of exit
    snap();
    hold(1, 0, 10);
    hold(0, 0, 10);
    hold(0, 1, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("back pulses", (c_in - s_in) + (c_out - s_out) + (c_err - s_err) + (c_den - s_den), 0);
    chk("back gate cycles", c_gate - s_gate, 40);

    // Bouncing A never settles long enough
    snap();
    for (int i = 0; i < 5; i++) begin
      hold(1, 0, 2);
      hold(0, 0, 2);
    end
    hold(0, 0, 10);
    chk("bounce pulses", (c_in - s_in) + (c_out - s_out) + (c_err - s_err) + (c_den - s_den), 0);
    chk("bounce gate cycles", c_gate - s_gate, 0);

    // Both beams at once from IDLE
    snap();
    hold(1, 1, 10);
    chk("both error", c_err - s_err, 1);
    chk("both gate", int'(gate_open), 0);
    hold(0, 0, 10);
    snap();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("after clear car_in", c_in - s_in, 1);
    chk("after clear error", c_err - s_err, 0);

    // A held long: watchdog only when enabled
    snap();
    hold(1, 0, 60);
    hold(0, 0, 10);
`ifdef PARK_GATE_TIMEOUT_EN
    chk("tmo error", c_err - s_err, 1);
    chk("tmo gate cycles", c_gate - s_gate, 50);
`else
    chk("no tmo error", c_err - s_err, 0);
    chk("no tmo gate cycles", c_gate - s_gate, 60);
`endif

    // Reset in the middle of an entry
    hold(1, 0, 10);
    hold(1, 1, 10);
    chk("mid gate before rst", int'(gate_open), 1);
    rst = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    @(negedge clk);
    chk("mid rst gate", int'(gate_open), 0);
    chk("mid rst pulses", int'(car_in) + int'(car_out) + int'(denied) + int'(error), 0);
    rst = 1'b0;
    snap();
    hold(0, 0, 20);
    chk("post rst pulses", (c_in - s_in) + (c_out - s_out) + (c_err - s_err) + (c_den - s_den), 0);
    chk("post rst gate cycles", c_gate - s_gate, 0);
    snap();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("post rst car_in", c_in - s_in, 1);

    chk("exclusive pulses", c_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
